// File: rtl/rf_writeback_unit.sv
// rtl/rf_writeback_unit.sv - register-file write-side controller merging ALU results and in-order load responses
module rf_writeback_unit #(
    parameter int DEPTH = 4
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_alu_valid,
    input  logic [4:0]               i_alu_rd,
    input  logic [31:0]              i_alu_data,
    output logic                     o_alu_ready,
    input  logic                     i_ld_issue,
    input  logic [4:0]               i_ld_rd,
    output logic                     o_ld_ready,
    input  logic                     i_mem_rsp_valid,
    input  logic [31:0]              i_mem_rsp_data,
    input  logic [4:0]               i_rs,
    input  logic [4:0]               i_rt,
    output logic                     o_hazard,
    output logic [31:0]              o_busy,
    output logic [$clog2(DEPTH):0]   o_pending_cnt,
    output logic                     o_wr_en,
    output logic [4:0]               o_wr_addr,
    output logic [31:0]              o_wr_data,
    output logic                     o_rsp_err
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [4:0]    r_q [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_cnt;
    logic [31:0]   r_busy;
    logic          r_wr_en;
    logic [4:0]    r_wr_addr;
    logic [31:0]   r_wr_data;
    logic          r_rsp_err;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_alu_acc;
    logic [4:0]    w_head;
    logic [31:0]   w_set_mask;
    logic [31:0]   w_clr_mask;

    // Readiness looks only at registered state, so a same-cycle pop never frees a slot or register early.
    always_comb begin
        w_full      = (r_cnt == FULL_CNT);
        w_empty     = (r_cnt == '0);
        w_head      = r_q[r_rd_ptr];
        o_ld_ready  = !w_full && ((i_ld_rd == 5'd0) || !r_busy[i_ld_rd]);
        o_alu_ready = !i_mem_rsp_valid && ((i_alu_rd == 5'd0) || !r_busy[i_alu_rd]);
        o_hazard    = ((i_rs != 5'd0) && r_busy[i_rs]) || ((i_rt != 5'd0) && r_busy[i_rt]);
        w_push      = i_ld_issue && o_ld_ready;
        w_pop       = i_mem_rsp_valid && !w_empty;
        w_alu_acc   = i_alu_valid && o_alu_ready;
        w_set_mask  = '0;
        w_clr_mask  = '0;
        if (w_push && (i_ld_rd != 5'd0)) begin
            w_set_mask[i_ld_rd] = 1'b1;
        end
        if (w_pop) begin
            w_clr_mask[w_head] = 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_q[r_wr_ptr] <= i_ld_rd;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rd_ptr  <= '0;
            r_wr_ptr  <= '0;
            r_cnt     <= '0;
            r_busy    <= '0;
            r_wr_en   <= 1'b0;
            r_wr_addr <= 5'd0;
            r_wr_data <= 32'd0;
            r_rsp_err <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_cnt <= r_cnt + (AW + 1)'(1);
                2'b01:   r_cnt <= r_cnt - (AW + 1)'(1);
                default: r_cnt <= r_cnt;
            endcase
            // Push and pop never target the same nonzero register: a busy register cannot be issued.
            r_busy <= (r_busy & ~w_clr_mask) | w_set_mask;
            if (i_mem_rsp_valid && w_empty) begin
                r_rsp_err <= 1'b1;
            end
            if (w_pop) begin
                r_wr_en   <= (w_head != 5'd0);
                r_wr_addr <= w_head;
                r_wr_data <= i_mem_rsp_data;
            end else if (w_alu_acc) begin
                r_wr_en   <= (i_alu_rd != 5'd0);
                r_wr_addr <= i_alu_rd;
                r_wr_data <= i_alu_data;
            end else begin
                r_wr_en   <= 1'b0;
            end
        end
    end

    assign o_busy        = r_busy;
    assign o_pending_cnt = r_cnt;
    assign o_wr_en       = r_wr_en;
    assign o_wr_addr     = r_wr_addr;
    assign o_wr_data     = r_wr_data;
    assign o_rsp_err     = r_rsp_err;

endmodule

// File: tb/tb_rf_writeback_unit.sv
// tb/tb_rf_writeback_unit.sv - vector table, reset corner case and random run against a queue-based model
module tb_rf_writeback_unit;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        ld_issue;
    logic [4:0]  ld_rd;
    logic        ld_ready;
    logic        mem_rsp_valid;
    logic [31:0] mem_rsp_data;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic        hazard;
    logic [31:0] busy;
    logic [2:0]  pending_cnt;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [31:0] wr_data;
    logic        rsp_err;

    int n_checks = 0;
    int n_pass   = 0;

    rf_writeback_unit #(.DEPTH(DEPTH)) dut (
        .i_clk(clk), .i_rst(rst),
        .i_alu_valid(alu_valid), .i_alu_rd(alu_rd), .i_alu_data(alu_data), .o_alu_ready(alu_ready),
        .i_ld_issue(ld_issue), .i_ld_rd(ld_rd), .o_ld_ready(ld_ready),
        .i_mem_rsp_valid(mem_rsp_valid), .i_mem_rsp_data(mem_rsp_data),
        .i_rs(rs), .i_rt(rt), .o_hazard(hazard),
        .o_busy(busy), .o_pending_cnt(pending_cnt),
        .o_wr_en(wr_en), .o_wr_addr(wr_addr), .o_wr_data(wr_data), .o_rsp_err(rsp_err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [31:0] adat;
        logic        li;
        logic [4:0]  lrd;
        logic        mv;
        logic [31:0] mdat;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        e_ardy;
        logic        e_lrdy;
        logic        e_haz;
        logic        e_wen;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
        logic [2:0]  e_cnt;
        logic [31:0] e_busy;
        logic        e_err;
    } vec_t;

    vec_t tbl[$];

    // Reference model: the queue of destinations is the whole state; busy is derived from it.
    int          m_q[$];
    logic        m_wen;
    logic [4:0]  m_waddr;
    logic [31:0] m_wdata;
    logic        m_err;

    function automatic vec_t mk(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                                input logic li, input logic [4:0] lrd,
                                input logic mv, input logic [31:0] mdat,
                                input logic [4:0] srs, input logic [4:0] srt,
                                input logic ardy, input logic lrdy, input logic haz,
                                input logic wen, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic [2:0] cnt, input logic [31:0] bsy, input logic err);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat; v.li = li; v.lrd = lrd;
        v.mv = mv; v.mdat = mdat; v.rs = srs; v.rt = srt;
        v.e_ardy = ardy; v.e_lrdy = lrdy; v.e_haz = haz;
        v.e_wen = wen; v.e_waddr = waddr; v.e_wdata = wdata;
        v.e_cnt = cnt; v.e_busy = bsy; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endtask

    task automatic drive(input logic av, input logic [4:0] ard, input logic [31:0] adat,
                         input logic li, input logic [4:0] lrd,
                         input logic mv, input logic [31:0] mdat,
                         input logic [4:0] srs, input logic [4:0] srt);
        alu_valid = av; alu_rd = ard; alu_data = adat;
        ld_issue = li; ld_rd = lrd;
        mem_rsp_valid = mv; mem_rsp_data = mdat;
        rs = srs; rt = srt;
    endtask

    task automatic do_reset();
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        m_q.delete();
        m_wen = 1'b0; m_waddr = 5'd0; m_wdata = 32'd0; m_err = 1'b0;
    endtask

    function automatic logic [31:0] m_busy();
        logic [31:0] b = '0;
        foreach (m_q[k]) if (m_q[k] != 0) b[m_q[k]] = 1'b1;
        return b;
    endfunction

    initial begin
        logic [31:0] mb;
        logic        e_ardy, e_lrdy, e_haz, pop, push;
        int          head;

        rst = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #12;
        chk("reset.wen",   32'(wr_en), 32'd0);
        chk("reset.waddr", 32'(wr_addr), 32'd0);
        chk("reset.wdata", wr_data, 32'd0);
        chk("reset.busy",  busy, 32'd0);
        chk("reset.cnt",   32'(pending_cnt), 32'd0);
        chk("reset.err",   32'(rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        tbl.push_back(mk(1, 3, 32'h12345678, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 3, 32'h12345678, 0, 32'h0, 0));
        tbl.push_back(mk(1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD, 1, 32'h20, 0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD, 2, 32'h60, 0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD, 3, 32'hE0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 8, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'hDEAD, 4, 32'h1E0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 9, 0, 0, 5, 0, 1, 0, 1, 0, 0, 32'hDEAD, 4, 32'h1E0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 9, 1, 32'hA, 0, 0, 0, 0, 0, 1, 5, 32'hA, 3, 32'h1C0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hB, 0, 0, 0, 1, 0, 1, 6, 32'hB, 2, 32'h180, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hC, 0, 0, 0, 1, 0, 1, 7, 32'hC, 1, 32'h100, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hD, 0, 0, 0, 1, 0, 1, 8, 32'hD, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 0, 0, 0, 0, 1, 1, 0, 0, 8, 32'hD, 1, 32'h20, 0));
        tbl.push_back(mk(1, 5, 32'h55, 0, 0, 0, 0, 0, 5, 0, 1, 1, 0, 8, 32'hD, 1, 32'h20, 0));
        tbl.push_back(mk(1, 5, 32'h55, 1, 5, 1, 32'h77, 5, 0, 0, 0, 1, 1, 5, 32'h77, 0, 32'h0, 0));
        tbl.push_back(mk(1, 5, 32'h55, 0, 0, 0, 0, 5, 0, 1, 1, 0, 1, 5, 32'h55, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 9, 0, 0, 0, 0, 1, 1, 0, 0, 5, 32'h55, 1, 32'h200, 0));
        tbl.push_back(mk(1, 10, 32'h1010, 0, 0, 1, 32'h99, 0, 0, 0, 1, 0, 1, 9, 32'h99, 0, 32'h0, 0));
        tbl.push_back(mk(1, 10, 32'h1010, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 10, 32'h1010, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 0, 10, 32'h1010, 1, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'hFF, 0, 0, 0, 1, 0, 0, 0, 32'hFF, 0, 32'h0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h33, 0, 0, 0, 1, 0, 0, 0, 32'hFF, 0, 32'h0, 1));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 32'hFF, 0, 32'h0, 1));

        foreach (tbl[i]) begin
            @(negedge clk);
            drive(tbl[i].av, tbl[i].ard, tbl[i].adat, tbl[i].li, tbl[i].lrd,
                  tbl[i].mv, tbl[i].mdat, tbl[i].rs, tbl[i].rt);
            #1;
            chk($sformatf("v%0d.alu_ready", i), 32'(alu_ready), 32'(tbl[i].e_ardy));
            chk($sformatf("v%0d.ld_ready", i),  32'(ld_ready),  32'(tbl[i].e_lrdy));
            chk($sformatf("v%0d.hazard", i),    32'(hazard),    32'(tbl[i].e_haz));
            @(posedge clk);
            #1;
            chk($sformatf("v%0d.wr_en", i),   32'(wr_en),       32'(tbl[i].e_wen));
            chk($sformatf("v%0d.wr_addr", i), 32'(wr_addr),     32'(tbl[i].e_waddr));
            chk($sformatf("v%0d.wr_data", i), wr_data,          tbl[i].e_wdata);
            chk($sformatf("v%0d.cnt", i),     32'(pending_cnt), 32'(tbl[i].e_cnt));
            chk($sformatf("v%0d.busy", i),    busy,             tbl[i].e_busy);
            chk($sformatf("v%0d.rsp_err", i), 32'(rsp_err),     32'(tbl[i].e_err));
        end

        // Reset in the middle of a cycle with two loads outstanding and a write pending.
        do_reset();
        drive(0, 0, 0, 1, 1, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 4, 32'h44, 1, 2, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        chk("midrst.pre_wen",  32'(wr_en), 32'd1);
        chk("midrst.pre_cnt",  32'(pending_cnt), 32'd2);
        chk("midrst.pre_busy", busy, 32'h6);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        rst = 1'b1;
        #1;
        chk("midrst.wen",   32'(wr_en), 32'd0);
        chk("midrst.waddr", 32'(wr_addr), 32'd0);
        chk("midrst.wdata", wr_data, 32'd0);
        chk("midrst.busy",  busy, 32'd0);
        chk("midrst.cnt",   32'(pending_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 1, 32'h5, 0, 0);
        @(posedge clk);
        #1;
        chk("midrst.late_err", 32'(rsp_err), 32'd1);
        chk("midrst.late_wen", 32'(wr_en), 32'd0);

        do_reset();
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            drive($urandom_range(0, 1), 5'($urandom_range(0, 7)), $urandom,
                  ($urandom_range(0, 9) < 4), 5'($urandom_range(0, 7)),
                  (m_q.size() > 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 49) == 0),
                  $urandom, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)));
            #1;
            mb     = m_busy();
            e_lrdy = (m_q.size() < DEPTH) && (ld_rd == 0 || !mb[ld_rd]);
            e_ardy = !mem_rsp_valid && (alu_rd == 0 || !mb[alu_rd]);
            e_haz  = (rs != 0 && mb[rs]) || (rt != 0 && mb[rt]);
            chk($sformatf("r%0d.alu_ready", c), 32'(alu_ready), 32'(e_ardy));
            chk($sformatf("r%0d.ld_ready", c),  32'(ld_ready),  32'(e_lrdy));
            chk($sformatf("r%0d.hazard", c),    32'(hazard),    32'(e_haz));
            pop  = mem_rsp_valid && (m_q.size() > 0);
            push = ld_issue && e_lrdy;
            if (mem_rsp_valid && m_q.size() == 0) m_err = 1'b1;
            if (pop) begin
                head = m_q.pop_front();
                m_wen = (head != 0); m_waddr = 5'(head); m_wdata = mem_rsp_data;
            end else if (alu_valid && e_ardy) begin
                m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
            end else begin
                m_wen = 1'b0;
            end
            if (push) m_q.push_back(int'(ld_rd));
            @(posedge clk);
            #1;
            chk($sformatf("r%0d.wr_en", c),   32'(wr_en),       32'(m_wen));
            chk($sformatf("r%0d.wr_addr", c), 32'(wr_addr),     32'(m_waddr));
            chk($sformatf("r%0d.wr_data", c), wr_data,          m_wdata);
            chk($sformatf("r%0d.cnt", c),     32'(pending_cnt), 32'(m_q.size()));
            chk($sformatf("r%0d.busy", c),    busy,             m_busy());
            chk($sformatf("r%0d.rsp_err", c), 32'(rsp_err),     32'(m_err));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
